// File: rtl/alu_result_demux_pkg.sv
// Shared ALU definitions: result/operand destination select encodings.
package alu_result_demux_pkg;

  typedef enum logic [1:0] {
    SEL_A   = 2'b00,
    SEL_B   = 2'b01,
    SEL_C   = 2'b10,
    SEL_ILL = 2'b11
  } alu_sel_e;

  function automatic logic sel_legal(input logic [1:0] sel);
    return sel != SEL_ILL;
  endfunction

endpackage

// File: rtl/alu_result_demux_fifo.sv
// result_fifo: circular buffer of {sel,data} entries with occupancy count.
module result_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wr_data,
  output logic [W-1:0]                 rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  // Storage is not reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_demux.sv
// Routes buffered ALU results to one of three destination channels, in order.
module alu_result_demux
  import alu_result_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH-1:0]    in_data,
  input  logic [1:0]                 in_sel,
  output logic signed [WIDTH-1:0]    a_data,
  output logic signed [WIDTH-1:0]    b_data,
  output logic signed [WIDTH-1:0]    c_data,
  output logic                       a_valid,
  output logic                       b_valid,
  output logic                       c_valid,
  input  logic                       a_ready,
  input  logic                       b_ready,
  input  logic                       c_ready,
  output logic                       err,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [WIDTH+1:0]        head;
  logic [1:0]              head_sel;
  logic signed [WIDTH-1:0] head_data;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && sel_legal(in_sel);
  assign head_sel  = head[WIDTH+1:WIDTH];
  assign head_data = head[WIDTH-1:0];

  result_fifo #(
    .W     (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({in_sel, in_data}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    a_valid = !empty && (head_sel == SEL_A);
    b_valid = !empty && (head_sel == SEL_B);
    c_valid = !empty && (head_sel == SEL_C);
    a_data  = a_valid ? head_data : '0;
    b_data  = b_valid ? head_data : '0;
    c_data  = c_valid ? head_data : '0;
    pop     = (a_valid && a_ready) || (b_valid && b_ready) || (c_valid && c_ready);
  end

  // A new illegal accept wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && !sel_legal(in_sel)) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_demux.sv
// Bench for alu_result_demux: queue model compared every cycle plus directed literals.
module tb_alu_result_demux;

  localparam int W = 8;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic [7:0] a_data, b_data, c_data;
  logic       a_valid, b_valid, c_valid;
  logic       a_ready = 1'b0, b_ready = 1'b0, c_ready = 1'b0;
  logic       err;
  logic       err_clr = 1'b0;
  logic [1:0] count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_demux #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .a_data(a_data), .b_data(b_data), .c_data(c_data),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready),
    .err(err), .err_clr(err_clr), .count(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an ordered list of pending {sel,data} words and a sticky flag.
  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit take, acc;
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      take = 1'b0;
      if (q.size() > 0) begin
        case (q[0].sel)
          2'd0: take = a_ready;
          2'd1: take = b_ready;
          2'd2: take = c_ready;
          default: take = 1'b0;
        endcase
      end
      acc = in_valid && (q.size() < D);
      if (acc && in_sel == 2'd3) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (take) void'(q.pop_front());
      if (acc && in_sel != 2'd3) q.push_back({in_sel, in_data});
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] hs;
    logic [7:0] hd;
    bit         ne;
    ne = q.size() > 0;
    hs = 2'd3;
    hd = '0;
    if (ne) begin
      hs = q[0].sel;
      hd = q[0].data;
    end
    check("m_a_valid", a_valid, ne && hs == 2'd0);
    check("m_b_valid", b_valid, ne && hs == 2'd1);
    check("m_c_valid", c_valid, ne && hs == 2'd2);
    check("m_a_data", a_data, (ne && hs == 2'd0) ? hd : 8'h00);
    check("m_b_data", b_data, (ne && hs == 2'd1) ? hd : 8'h00);
    check("m_c_data", c_data, (ne && hs == 2'd2) ? hd : 8'h00);
    check("m_count", count, q.size());
    check("m_in_ready", in_ready, q.size() != D);
    check("m_err", err, m_err);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
  endtask

  task automatic set_ready(input logic a, input logic b, input logic c);
    a_ready = a;
    b_ready = b;
    c_ready = c;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_a_valid", a_valid, 0);
    check("rst_err", err, 0);
    step();
    step();
    rst_n = 1'b1;

    // Basic in-order routing to three channels
    set_ready(1, 1, 1);
    offer(8'd5, 2'b00);
    step();
    check("t1_a_valid", a_valid, 1);
    check("t1_a_data", a_data, 8'd5);
    offer(8'd10, 2'b01);
    step();
    check("t1_b_valid", b_valid, 1);
    check("t1_b_data", b_data, 8'd10);
    check("t1_a_valid_lo", a_valid, 0);
    offer(8'd15, 2'b10);
    step();
    check("t1_c_data", c_data, 8'd15);
    check("t1_count1", count, 1);
    in_valid = 1'b0;
    step();
    check("t1_count0", count, 0);

    // Backpressure: third word held while full
    set_ready(0, 0, 0);
    offer(8'd1, 2'b00);
    step();
    offer(8'd2, 2'b00);
    step();
    offer(8'd3, 2'b00);
    check("t2_full_count", count, 2);
    check("t2_in_ready0", in_ready, 0);
    step();
    check("t2_held_count", count, 2);
    check("t2_head", a_data, 8'd1);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    check("t2_after_pop", count, 1);
    check("t2_ready1", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t2_accepted3", count, 2);
    check("t2_head2", a_data, 8'd2);
    a_ready = 1'b1;
    step();
    check("t2_head3", a_data, 8'd3);
    step();
    check("t2_drained", count, 0);

    // Illegal select, clear, and clear colliding with new illegal
    set_ready(1, 1, 1);
    offer(8'hF9, 2'b11);
    step();
    in_valid = 1'b0;
    check("t3_err", err, 1);
    check("t3_count", count, 0);
    check("t3_novalid", {a_valid, b_valid, c_valid}, 3'b000);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_cleared", err, 0);
    offer(8'hF9, 2'b11);
    err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    err_clr = 1'b0;
    check("t3_set_wins", err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Head-of-line: ready on unselected channel is ignored
    set_ready(0, 0, 0);
    offer(8'd20, 2'b01);
    step();
    offer(8'd21, 2'b00);
    step();
    in_valid = 1'b0;
    a_ready = 1'b1;
    step();
    check("t4_blocked_count", count, 2);
    check("t4_b_valid", b_valid, 1);
    check("t4_b_data", b_data, 8'd20);
    check("t4_a_data0", a_data, 8'd0);
    b_ready = 1'b1;
    step();
    check("t4_a_data", a_data, 8'd21);
    check("t4_count1", count, 1);
    step();
    check("t4_count0", count, 0);

    // Asynchronous reset mid-stream
    set_ready(0, 0, 0);
    offer(8'd40, 2'b10);
    step();
    offer(8'd41, 2'b10);
    step();
    in_valid = 1'b0;
    check("t5_pre_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_count", count, 0);
    check("t5_async_c_valid", c_valid, 0);
    check("t5_async_c_data", c_data, 8'd0);
    check("t5_async_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    set_ready(1, 1, 1);
    step();
    step();
    check("t5_idle_valid", {a_valid, b_valid, c_valid}, 3'b000);
    offer(8'd42, 2'b01);
    step();
    in_valid = 1'b0;
    check("t5_new_b", b_data, 8'd42);
    step();

    // Streaming with wrap: count holds at 1 and each word appears in order
    set_ready(1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] v;
      v = 8'(30 + i);
      offer(v, 2'(i % 3));
      step();
      check("t6_count", count, 1);
      case (i % 3)
        0: check("t6_a", a_data, v);
        1: check("t6_b", b_data, v);
        default: check("t6_c", c_data, v);
      endcase
    end
    in_valid = 1'b0;
    step();
    check("t6_drained", count, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_demux.md
ALU_RESULT_DEMUX -- requirements
Module: alu_result_demux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the signed operand/result width.
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the number of buffered result entries (power of two, >=2).
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  the result word on in_data/in_sel is offered.
REQ-006 Port in_ready  output  1  the block accepts the offered word this cycle.
REQ-007 Port in_data  input  WIDTH  signed result word.
REQ-008 Port in_sel  input  2  destination select: 00=a, 01=b, 10=c, 11=illegal.
REQ-009 Ports a_data/b_data/c_data  output  WIDTH  signed destination data, one per channel.
REQ-010 Ports a_valid/b_valid/c_valid  output  1  a word is presented on that channel.
REQ-011 Ports a_ready/b_ready/c_ready  input  1  the destination takes the presented word.
REQ-012 Port err  output  1  sticky flag: an illegal select was received.
REQ-013 Port err_clr  input  1  synchronous clear of err.
REQ-014 Port count  output  $clog2(DEPTH+1)  current number of buffered entries.

Function
REQ-015 A transfer in SHALL occur when in_valid && in_ready are both high at a rising edge.
REQ-016 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on any x_ready (no full-pass-through).
REQ-017 An accepted word with in_sel 00/01/10 SHALL be written as {sel,data} at the write pointer; pointers SHALL wrap modulo DEPTH.
REQ-018 An accepted word with in_sel=11 SHALL be consumed without enqueue and SHALL set err on the following edge.
REQ-019 err SHALL remain set until err_clr is sampled high; if err_clr and a new illegal accept coincide, err SHALL be 1 afterwards.
REQ-020 When count>0, exactly one x_valid SHALL be high: the one selected by the head entry's sel; all x_valid SHALL be 0 when count==0.
REQ-021 The selected channel's x_data SHALL equal the head data; unselected channels' x_data SHALL be 0.
REQ-022 The head SHALL pop when its selected x_valid && x_ready are high; ready on unselected channels SHALL be ignored.
REQ-023 Delivery SHALL be strictly in acceptance order (head-of-line blocking permitted).
REQ-024 Minimum latency from accept edge to x_valid high SHALL be one cycle (entry visible after the write edge).
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push-only +1; pop-only -1; count SHALL never exceed DEPTH nor go below 0.
REQ-026 Data SHALL pass unmodified; no sign extension or truncation occurs inside the block.

Reset
REQ-027 While rst_n is low: count=0, pointers=0, err=0, in_ready=1, all x_valid=0, all x_data=0, immediately and independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries; no partial transfer SHALL be reported after release.
REQ-029 The first possible accept SHALL be the first rising edge after rst_n deasserts.

Structure
REQ-030 Select encodings (SEL_A, SEL_B, SEL_C, SEL_ILL) SHALL be constants in a shared ALU package also used by the ALU operand mux.
REQ-031 The buffer SHALL be one sub-module, result_fifo (push/pop/full/empty/count, WIDTH+2 bits wide); decode and err logic SHALL remain in alu_result_demux.

Verification
REQ-032 Reset, then push (5,sel 00),(10,sel 01),(15,sel 10) with all ready=1 -> a then b then c valid on successive cycles carrying 5,10,15; count returns to 0.
REQ-033 All ready=0, push 3 words -> two accepted, in_ready=0 with count=2, third held until a_ready pulses, then accepted.
REQ-034 Push (-7,sel 11) -> no x_valid, count stays 0, err=1 next cycle; pulse err_clr -> err=0.
REQ-035 Head sel=01 with a_ready=1,b_ready=0 -> no pop; raise b_ready -> b_data=head, pop, order preserved.
REQ-036 Assert rst_n=0 mid-stream with count=2 -> outputs zero asynchronously; after release no x_valid until new push.
REQ-037 Continuous push/pop for 10 words with ready=1 -> pointers wrap, count steady at 1, every value delivered in order.
